sort_ctrl: RTL and testbench
============================

# sort_ctrl

Job sequencer for the streaming sort engine. An AXI-Lite register file holds `ap_start`, `ap_done`, `ap_idle` and the job length. A four-phase FSM admits exactly `data_length` words from the input AXI-Stream into the engine, triggers the sort, then drains the same count to the output stream with a generated `sm_tlast`. It sits between the host-facing AXI-Lite/AXI-Stream ports and the sort datapath core.

## Interface
- pADDR_WIDTH, 12, AXI-Lite address width
- pDATA_WIDTH, 32, register and stream data width
- pMAX_LEN, 64, maximum job length in words; must be a power of two ≥ 2
- axis_clk  in  1  sole clock, rising edge
- axis_rst  in  1  reset; asynchronous assertion, active-high
- awvalid/awready, wvalid/wready  in/out  1 each  AXI-Lite write address and data handshakes
- awaddr  in  pADDR_WIDTH ; wdata  in  pDATA_WIDTH
- arvalid/arready  in/out  1 ; araddr  in  pADDR_WIDTH
- rvalid  out  1 ; rready  in  1 ; rdata  out  pDATA_WIDTH
- ss_tvalid  in  1 ; ss_tready  out  1 ; ss_tdata  in  pDATA_WIDTH ; ss_tlast  in  1 (ignored)  host input stream
- core_in_valid  out  1 ; core_in_ready  in  1 ; core_in_data  out  pDATA_WIDTH  engine load port
- core_go  out  1  one-cycle pulse to start the sort
- core_done  in  1  one-cycle pulse when the sort completes
- core_out_valid  in  1 ; core_out_ready  out  1 ; core_out_data  in  pDATA_WIDTH  engine drain port
- sm_tvalid  out  1 ; sm_tready  in  1 ; sm_tdata  out  pDATA_WIDTH ; sm_tlast  out  1  host output stream

## Operation
- Registers, word-aligned:
  - 0x00 ap_ctrl
    - bit0 ap_start: write 1 while idle; self-clears when LOAD is entered.
    - bit1 ap_done: sticky; cleared by any read of 0x00.
    - bit2 ap_idle.
  - 0x10 data_length, reset value 0.
    - Writes above pMAX_LEN saturate to pMAX_LEN.
    - Writes are ignored unless the FSM is in IDLE.
  - Unmapped reads return 0; unmapped writes are dropped.
- States and transitions:
  - IDLE: waits for ap_start. On ap_start, go to LOAD; if data_length==0, go directly to DONE.
  - LOAD: `ss_tready = core_in_ready`, `core_in_valid = ss_tvalid`, data passes through combinationally. Count each word where valid && ready. At count==data_length, go to SORT.
  - SORT: assert core_go for exactly the first cycle in this state. Stay until core_done, then go to DRAIN.
  - DRAIN: `sm_tvalid = core_out_valid`, `core_out_ready = sm_tready`, data passes through. `sm_tlast=1` on the word where count==data_length-1. After that word is accepted, go to DONE.
  - DONE: set ap_done, go to IDLE.
- Stream gating: outside LOAD, ss_tready=0 and core_in_valid=0. Outside DRAIN, sm_tvalid=0 and core_out_ready=0.
- Word counter width is clog2(pMAX_LEN)+1. It clears on entry to LOAD and on entry to DRAIN.
- ap_idle=1 only in IDLE.
- A core_done seen outside SORT is ignored.
- Asserting axis_rst mid-job returns the FSM to IDLE, clears all counters and registers, and drops any in-flight beat.

## Timing
- Output reset values:
  - awready, wready, arready, rvalid, core_go, sm_tlast = 0
  - rdata = 0
  - ss_tready, core_in_valid, core_out_ready, sm_tvalid = 0
  - ap_idle reads 1 after reset.
- AXI-Lite write: awready and wready pulse together for one cycle when awvalid && wvalid are both high. The register updates on that same edge.
- AXI-Lite read: arready pulses one cycle after arvalid. rvalid rises on the next cycle and holds until rready. rdata is stable while rvalid is high.
- Phase latencies:
  - ap_start write edge → LOAD on the next cycle.
  - Last LOAD beat → core_go one cycle later.
  - core_done → DRAIN on the next cycle.
  - Last DRAIN beat → ap_done visible on a read issued two cycles later.
- Stream paths add zero latency. Backpressure on either side stalls the counter.
- A write to 0x00 with bit0=1 while not idle is ignored and does not queue.

## Configuration
- `SORT_CTRL_PERF_EN` defined:
  - Adds a 32-bit cycle counter at 0x14 that counts every cycle outside IDLE and clears on ap_start.
  - The counter saturates at 0xFFFF_FFFF.
- Not defined: 0x14 reads 0 and no counter flops are built.

## Structure
- Shared package `sort_pkg` holds:
  - the FSM state enum (IDLE, LOAD, SORT, DRAIN, DONE);
  - register offset constants AP_CTRL=0x00, DATA_LEN=0x10, PERF_CYC=0x14;
  - ap_ctrl bit indices.
- One sub-module, `sort_ctrl_regs`: the AXI-Lite slave and register file. It exports start_pulse and data_length and takes done_set and idle as inputs. The FSM and stream gating stay in the top module.

## Test plan
- Length 11, inputs 11..1, engine model sorts ascending → sm outputs 1..11, sm_tlast only on word 11, exactly one core_go pulse, 0x00 read = 0x6, a second read = 0x4.
- Length 0 with ap_start → no ss_tready, no core_go; ap_done=1 within 3 cycles.
- Length write of 100 → reads back 64 (pMAX_LEN). A length write during LOAD is ignored and the readback is unchanged.
- sm_tready toggled 1/0 every cycle during DRAIN with length 8 → all 8 words delivered in order, sm_tlast on the 8th, no duplicate words.
- axis_rst asserted after 5 of 11 LOAD beats → ss_tready=0 next edge, 0x00 reads 0x4. A fresh job then completes correctly.
- With SORT_CTRL_PERF_EN, engine sort latency 20 cycles, length 4 → 0x14 reads a nonzero value equal to the cycles spent outside IDLE. Without the macro, 0x14 reads 0.

Source files
------------

// File: rtl/sort_pkg.sv
// sort_pkg: shared types and register map for the sort job sequencer.
// Holds the FSM state enum, AXI-Lite offsets and ap_ctrl bit positions.
package sort_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SORT,
    DRAIN,
    DONE
  } state_t;

  localparam int AP_CTRL  = 'h00;
  localparam int DATA_LEN = 'h10;
  localparam int PERF_CYC = 'h14;

  localparam int AP_START_BIT = 0;
  localparam int AP_DONE_BIT  = 1;
  localparam int AP_IDLE_BIT  = 2;

endpackage

// File: rtl/sort_ctrl_regs.sv
// sort_ctrl_regs: AXI-Lite slave and register file for sort_ctrl.
// Ports: aw/w/ar/r AXI-Lite channels; start_pulse and data_length out
// to the FSM; done_set and idle in from the FSM.
// Optional: SORT_CTRL_PERF_EN adds the busy-cycle counter at 0x14.
module sort_ctrl_regs
  import sort_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pMAX_LEN    = 64,
  localparam int LW = $clog2(pMAX_LEN) + 1
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic                   start_pulse,
  output logic [LW-1:0]          data_length,
  input  logic                   done_set,
  input  logic                   idle
);

  logic                   ap_start;
  logic                   ap_done;
  logic [LW-1:0]          len_q;
  logic [pADDR_WIDTH-1:0] ar_addr;
  logic [pDATA_WIDTH-1:0] rd_val;
  logic                   wr_en;
  logic                   ar_take;
  logic                   ctrl_rd;
  logic                   wr_ctrl;
  logic                   wr_len;

  assign wr_en   = awvalid && wvalid && !awready;
  assign wr_ctrl = wr_en && (awaddr == pADDR_WIDTH'(AP_CTRL));
  assign wr_len  = wr_en && (awaddr == pADDR_WIDTH'(DATA_LEN));
  assign ar_take = arvalid && !arready && !rvalid;
  // rdata is captured on the edge where arready is high
  assign ctrl_rd = arready && (ar_addr == pADDR_WIDTH'(AP_CTRL));

  assign start_pulse = ap_start && idle;
  assign data_length = len_q;

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      awready  <= 1'b0;
      wready   <= 1'b0;
      ap_start <= 1'b0;
      ap_done  <= 1'b0;
      len_q    <= '0;
    end else begin
      awready <= wr_en;
      wready  <= wr_en;
      if (start_pulse)
        ap_start <= 1'b0;
      else if (wr_ctrl && wdata[AP_START_BIT] && idle)
        ap_start <= 1'b1;
      // a completion landing on the clearing read wins
      if (done_set)
        ap_done <= 1'b1;
      else if (ctrl_rd)
        ap_done <= 1'b0;
      if (wr_len && idle) begin
        if (wdata > pDATA_WIDTH'(pMAX_LEN))
          len_q <= LW'(pMAX_LEN);
        else
          len_q <= wdata[LW-1:0];
      end
    end
  end

`ifdef SORT_CTRL_PERF_EN
  logic [31:0] perf_cyc;

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst)
      perf_cyc <= '0;
    else if (start_pulse)
      perf_cyc <= '0;
    else if (!idle && perf_cyc != '1)
      perf_cyc <= perf_cyc + 32'd1;
  end
`endif

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      ar_addr == pADDR_WIDTH'(AP_CTRL): begin
        rd_val[AP_START_BIT] = ap_start;
        rd_val[AP_DONE_BIT]  = ap_done;
        rd_val[AP_IDLE_BIT]  = idle;
      end
      ar_addr == pADDR_WIDTH'(DATA_LEN):
        rd_val = pDATA_WIDTH'(len_q);
`ifdef SORT_CTRL_PERF_EN
      ar_addr == pADDR_WIDTH'(PERF_CYC):
        rd_val = pDATA_WIDTH'(perf_cyc);
`endif
      default: ;
    endcase
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      ar_addr <= '0;
    end else begin
      arready <= ar_take;
      if (ar_take)
        ar_addr <= araddr;
      if (arready) begin
        rvalid <= 1'b1;
        rdata  <= rd_val;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sort_ctrl.sv
// sort_ctrl: job sequencer for the streaming sort engine.
// Ports: AXI-Lite regs, ss_* host input, core_in_*/core_go/core_done/
// core_out_* engine side, sm_* host output with generated sm_tlast.
// Optional: SORT_CTRL_PERF_EN (busy-cycle counter at 0x14).
module sort_ctrl
  import sort_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pMAX_LEN    = 64
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   ss_tvalid,
  output logic                   ss_tready,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   core_in_valid,
  input  logic                   core_in_ready,
  output logic [pDATA_WIDTH-1:0] core_in_data,
  output logic                   core_go,
  input  logic                   core_done,
  input  logic                   core_out_valid,
  output logic                   core_out_ready,
  input  logic [pDATA_WIDTH-1:0] core_out_data,
  output logic                   sm_tvalid,
  input  logic                   sm_tready,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast
);

  localparam int LW = $clog2(pMAX_LEN) + 1;

  state_t        state;
  logic [LW-1:0] cnt;
  logic [LW-1:0] data_length;
  logic          start_pulse;
  logic          done_set;
  logic          idle;
  logic          in_load;
  logic          in_drain;
  logic          in_beat;
  logic          out_beat;
  logic          last_out;
  logic          unused_tlast;

  // frame boundaries come from data_length, not the host
  assign unused_tlast = ss_tlast;

  assign done_set = state == DONE;
  assign idle     = state == IDLE;
  assign in_load  = state == LOAD;
  assign in_drain = state == DRAIN;

  sort_ctrl_regs #(
    .pADDR_WIDTH (pADDR_WIDTH),
    .pDATA_WIDTH (pDATA_WIDTH),
    .pMAX_LEN    (pMAX_LEN)
  ) u_regs (
    .axis_clk    (axis_clk),
    .axis_rst    (axis_rst),
    .awvalid     (awvalid),
    .awready     (awready),
    .awaddr      (awaddr),
    .wvalid      (wvalid),
    .wready      (wready),
    .wdata       (wdata),
    .arvalid     (arvalid),
    .arready     (arready),
    .araddr      (araddr),
    .rvalid      (rvalid),
    .rready      (rready),
    .rdata       (rdata),
    .start_pulse (start_pulse),
    .data_length (data_length),
    .done_set    (done_set),
    .idle        (idle)
  );

  assign ss_tready     = in_load && core_in_ready;
  assign core_in_valid = in_load && ss_tvalid;
  assign core_in_data  = ss_tdata;
  assign in_beat       = in_load && ss_tvalid && core_in_ready;

  assign last_out       = cnt == data_length - LW'(1);
  assign sm_tvalid      = in_drain && core_out_valid;
  assign core_out_ready = in_drain && sm_tready;
  assign sm_tdata       = core_out_data;
  assign sm_tlast       = in_drain && last_out;
  assign out_beat       = in_drain && core_out_valid && sm_tready;

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      core_go <= 1'b0;
    end else begin
      core_go <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_pulse) begin
            cnt   <= '0;
            state <= (data_length == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          if (in_beat) begin
            cnt <= cnt + LW'(1);
            if (cnt + LW'(1) == data_length) begin
              state   <= SORT;
              core_go <= 1'b1;
            end
          end
        end
        SORT: begin
          if (core_done) begin
            state <= DRAIN;
            cnt   <= '0;
          end
        end
        DRAIN: begin
          if (out_beat) begin
            if (last_out)
              state <= DONE;
            else
              cnt <= cnt + LW'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_ctrl.sv
// tb_sort_ctrl: scoreboard bench for sort_ctrl with a sorting engine model.
// Define SORT_CTRL_PERF_EN to check the 0x14 busy-cycle counter.
module tb_sort_ctrl;

  localparam logic [11:0] A_CTRL = 12'h000;
  localparam logic [11:0] A_LEN  = 12'h010;
  localparam logic [11:0] A_PERF = 12'h014;
  localparam logic [11:0] A_HOLE = 12'h008;

  logic        axis_clk = 1'b0;
  logic        axis_rst;
  logic        awvalid, awready, wvalid, wready;
  logic [11:0] awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic        arvalid, arready, rvalid, rready;
  logic        ss_tvalid, ss_tready, ss_tlast;
  logic [31:0] ss_tdata;
  logic        core_in_valid, core_in_ready;
  logic [31:0] core_in_data;
  logic        core_go, core_done;
  logic        core_out_valid, core_out_ready;
  logic [31:0] core_out_data;
  logic        sm_tvalid, sm_tready, sm_tlast;
  logic [31:0] sm_tdata;

  sort_ctrl dut (
    .axis_clk       (axis_clk),
    .axis_rst       (axis_rst),
    .awvalid        (awvalid),
    .awready        (awready),
    .awaddr         (awaddr),
    .wvalid         (wvalid),
    .wready         (wready),
    .wdata          (wdata),
    .arvalid        (arvalid),
    .arready        (arready),
    .araddr         (araddr),
    .rvalid         (rvalid),
    .rready         (rready),
    .rdata          (rdata),
    .ss_tvalid      (ss_tvalid),
    .ss_tready      (ss_tready),
    .ss_tdata       (ss_tdata),
    .ss_tlast       (ss_tlast),
    .core_in_valid  (core_in_valid),
    .core_in_ready  (core_in_ready),
    .core_in_data   (core_in_data),
    .core_go        (core_go),
    .core_done      (core_done),
    .core_out_valid (core_out_valid),
    .core_out_ready (core_out_ready),
    .core_out_data  (core_out_data),
    .sm_tvalid      (sm_tvalid),
    .sm_tready      (sm_tready),
    .sm_tdata       (sm_tdata),
    .sm_tlast       (sm_tlast)
  );

  always #5 axis_clk = ~axis_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] in_q[$];
  logic [32:0] exp_q[$];
  logic [31:0] ebuf[$];
  logic [31:0] obuf[$];

  int lat = 3;
  int timer = 0;
  bit rnd_in = 0;
  bit sm_tog = 0;
  bit rdy_seen = 0;
  bit last_seen = 0;
  int go_cnt = 0;
  int ss_cnt = 0;
  int t0 = 0;
  int last_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // one clock: sample handshakes mid-cycle, update bench drivers after edge
  task automatic step();
    logic        ss_b, in_b, out_b, sm_b, go_b;
    logic [31:0] in_d;
    logic [32:0] e;
    logic [31:0] tmp;
    int          k;
    @(negedge axis_clk);
    ss_b  = ss_tvalid && ss_tready;
    in_b  = core_in_valid && core_in_ready;
    in_d  = core_in_data;
    out_b = core_out_valid && core_out_ready;
    sm_b  = sm_tvalid && sm_tready;
    go_b  = core_go;
    if (ss_tready) rdy_seen = 1'b1;
    if (go_b) go_cnt++;
    if (sm_b) begin
      chk("sm_avail", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sm_data", sm_tdata, e[31:0]);
        chk("sm_tlast", 32'(sm_tlast), 32'(e[32]));
      end
      if (sm_tlast) begin
        last_seen = 1'b1;
        last_cyc  = cyc + 1;
      end
    end
    @(posedge axis_clk);
    cyc++;
    #1;
    if (axis_rst) begin
      in_q.delete();
      ebuf.delete();
      obuf.delete();
      timer     = 0;
      core_done = 1'b0;
    end else begin
      if (ss_b && in_q.size() > 0) begin
        tmp = in_q.pop_front();
        ss_cnt++;
      end
      if (in_b) begin
        k = 0;
        while (k < ebuf.size() && ebuf[k] <= in_d) k++;
        ebuf.insert(k, in_d);
      end
      if (out_b && obuf.size() > 0) tmp = obuf.pop_front();
      core_done = 1'b0;
      if (go_b) begin
        timer = lat;
      end else if (timer > 0) begin
        timer--;
        if (timer == 0) begin
          core_done = 1'b1;
          obuf = ebuf;
          ebuf.delete();
        end
      end
    end
    ss_tvalid = in_q.size() > 0;
    if (in_q.size() > 0) ss_tdata = in_q[0];
    else ss_tdata = '0;
    core_in_ready = rnd_in ? ($urandom_range(0, 1) == 1) : 1'b1;
    core_out_valid = obuf.size() > 0;
    if (obuf.size() > 0) core_out_data = obuf[0];
    else core_out_data = '0;
    sm_tready = sm_tog ? !sm_tready : 1'b1;
  endtask

  task automatic axi_wr(input logic [11:0] a, input logic [31:0] d);
    int n;
    n = 0;
    awaddr  = a;
    wdata   = d;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    do begin
      step();
      n++;
    end while (!awready && n < 20);
    chk("wr_ack", 32'({awready, wready}), 32'd3);
    t0 = cyc;
    awvalid = 1'b0;
    wvalid  = 1'b0;
  endtask

  task automatic axi_rd(input logic [11:0] a, output logic [31:0] d);
    int n;
    n = 0;
    araddr  = a;
    arvalid = 1'b1;
    do begin
      step();
      n++;
    end while (!arready && n < 20);
    arvalid = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!rvalid && n < 20);
    chk("rd_ack", 32'(rvalid), 32'd1);
    d = rdata;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a,
                        input logic [31:0] want);
    logic [31:0] d;
    axi_rd(a, d);
    chk(tag, d, want);
  endtask

  task automatic start_job(input int len);
    axi_wr(A_LEN, 32'(len));
    last_seen = 1'b0;
    go_cnt    = 0;
    axi_wr(A_CTRL, 32'd1);
  endtask

  task automatic feed(input int len, input bit rnd);
    logic [31:0] v;
    logic [31:0] s[$];
    int          k;
    for (int i = 0; i < len; i++) begin
      v = rnd ? 32'($urandom_range(0, 999)) : 32'(len - i);
      in_q.push_back(v);
      k = 0;
      while (k < s.size() && s[k] <= v) k++;
      s.insert(k, v);
    end
    for (int i = 0; i < len; i++)
      exp_q.push_back({(i == len - 1), s[i]});
  endtask

  task automatic wait_end(input string tag);
    int n;
    n = 0;
    while (!last_seen && n < 2000) begin
      step();
      n++;
    end
    chk(tag, 32'(last_seen), 32'd1);
    chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_go"}, 32'(go_cnt), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    int n;
    axis_rst = 1'b1;
    awvalid = 0; wvalid = 0; awaddr = 0; wdata = 0;
    arvalid = 0; araddr = 0; rready = 1'b1;
    ss_tvalid = 0; ss_tdata = 0; ss_tlast = 0;
    core_in_ready = 1'b1; core_done = 0;
    core_out_valid = 0; core_out_data = 0;
    sm_tready = 1'b1;
    repeat (3) step();
    chk("rst_outs",
        32'({awready, wready, arready, rvalid, core_go, sm_tlast,
             ss_tready, core_in_valid, core_out_ready, sm_tvalid}),
        32'd0);
    chk("rst_rdata", rdata, 32'd0);
    axis_rst = 1'b0;
    step();

    rd_chk("ctrl_rst", A_CTRL, 32'h4);
    rd_chk("len_rst", A_LEN, 32'd0);
    axi_wr(A_LEN, 32'd100);
    rd_chk("len_sat", A_LEN, 32'd64);
    axi_wr(A_LEN, 32'd64);
    rd_chk("len_max", A_LEN, 32'd64);
    axi_wr(A_HOLE, 32'd5);
    rd_chk("len_hole_wr", A_LEN, 32'd64);
    rd_chk("hole_rd", A_HOLE, 32'd0);

    // zero-length job skips straight to DONE
    rdy_seen = 0;
    start_job(0);
    step();
    step();
    rd_chk("zero_ctrl", A_CTRL, 32'h6);
    chk("zero_ss_rdy", 32'(rdy_seen), 32'd0);
    chk("zero_go", 32'(go_cnt), 32'd0);
    rd_chk("zero_ctrl2", A_CTRL, 32'h4);

    // length 11, descending input; locked length and stray start in LOAD
    start_job(11);
    axi_wr(A_LEN, 32'd5);
    axi_wr(A_CTRL, 32'd1);
    rd_chk("len_lock", A_LEN, 32'd11);
    feed(11, 1'b0);
    wait_end("jobA");
    rd_chk("jobA_ctrl", A_CTRL, 32'h6);
    rd_chk("jobA_ctrl2", A_CTRL, 32'h4);
    rdy_seen = 0;
    repeat (10) step();
    chk("no_queue", 32'(rdy_seen), 32'd0);

    // length 8 with drain backpressure and load stalls
    rnd_in = 1;
    sm_tog = 1;
    start_job(8);
    feed(8, 1'b1);
    wait_end("jobB");
    rnd_in = 0;
    sm_tog = 0;
    rd_chk("jobB_ctrl", A_CTRL, 32'h6);

    // reset after 5 of 11 load beats
    start_job(11);
    feed(11, 1'b0);
    ss_cnt = 0;
    n = 0;
    while (ss_cnt < 5 && n < 100) begin
      step();
      n++;
    end
    chk("rst_mid_beats", 32'(ss_cnt), 32'd5);
    chk("rst_mid_rdy_pre", 32'(ss_tready), 32'd1);
    axis_rst = 1'b1;
    step();
    chk("rst_mid_rdy", 32'(ss_tready), 32'd0);
    step();
    axis_rst = 1'b0;
    exp_q.delete();
    step();
    chk("rst_mid_go", 32'(go_cnt), 32'd0);
    rd_chk("rst_mid_ctrl", A_CTRL, 32'h4);
    rd_chk("rst_mid_len", A_LEN, 32'd0);
    start_job(3);
    feed(3, 1'b1);
    wait_end("jobC");
    rd_chk("jobC_ctrl", A_CTRL, 32'h6);

    // busy-cycle counter with a slow engine
    lat = 20;
    start_job(4);
    feed(4, 1'b0);
    wait_end("jobP");
    step();
    axi_rd(A_PERF, d);
`ifdef SORT_CTRL_PERF_EN
    chk("perf_nz", 32'(d != 0), 32'd1);
    chk("perf_cyc", d, 32'(last_cyc - t0));
`else
    chk("perf_off", d, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
